// File: rtl/mem_mp_arb_pkg.sv
// Shared types and constants for the multi-port arbitrated memory (mem_mp_arb).
// Optional build macro MEM_MP_PERF_EN is consumed by mem_mp_arb itself.
package mem_mp_arb_pkg;

  localparam int MP_MAX_PORTS = 8;
  localparam int MP_PORT_W    = $clog2(MP_MAX_PORTS);

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_mp_arb_if.sv
// Request/response bundle between memory-controller ports and mem_mp_arb.
// master = requesters, slave = the memory.
interface mem_mp_arb_if #(
  parameter int NPORTS    = 2,
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16
);
  logic [NPORTS-1:0]           req;
  logic [NPORTS-1:0]           we;
  logic [NPORTS*ADDRWIDTH-1:0] addr;
  logic [NPORTS*DATAWIDTH-1:0] wdata;
  logic [NPORTS-1:0]           gnt;
  logic [NPORTS-1:0]           rvalid;
  logic [DATAWIDTH-1:0]        rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_mp_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at rr_ptr,
// pointer advances past the winner on every granted cycle.
module mem_mp_arb_rr_arbiter
  import mem_mp_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetH,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] rr_ptr;

  // NOTE: every output gets a default before the loop so no path leaves a latch.
  always_comb begin
    logic [PW-1:0] p;
    logic          found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    p       = '0;
    for (int k = 0; k < N; k++) begin
      p = PW'((int'(rr_ptr) + k) % N);
      if (!found && req[p] == 1'b1) begin
        gnt[p]  = 1'b1;
        gnt_idx = p;
        found   = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (resetH)
      rr_ptr <= '0;
    else if (|gnt)
      rr_ptr <= PW'(wrap_inc(int'(gnt_idx), N));
  end

endmodule

// File: rtl/mem_mp_arb.sv
// N-port memory with round-robin arbitration and a tagged RD_LAT read pipeline.
// Define MEM_MP_PERF_EN to add per-port grant/stall counters.
module mem_mp_arb
  import mem_mp_arb_pkg::*;
#(
  parameter  int                   NPORTS     = 2,
  parameter  int                   DATAWIDTH  = 16,
  parameter  int                   MEMDEPTH   = 2**16,
  parameter  int                   RD_LAT     = 1,
  parameter  logic [DATAWIDTH-1:0] UNINIT_VAL = '0,
  localparam int                   ADDRWIDTH  = $clog2(MEMDEPTH),
  localparam int                   PW         = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 resetH,
  mem_mp_arb_if.slave          bus
`ifdef MEM_MP_PERF_EN
  ,
  output logic [NPORTS*32-1:0] perf_grants,
  output logic [NPORTS*32-1:0] perf_stalls
`endif
);

  typedef struct packed {
    logic                 valid;
    logic [MP_PORT_W-1:0] port;
    logic [DATAWIDTH-1:0] data;
  } mem_rsp_t;

  logic [NPORTS-1:0]    req_eff;
  logic [NPORTS-1:0]    gnt;
  logic [PW-1:0]        gnt_idx;
  logic [ADDRWIDTH-1:0] addr_a  [NPORTS];
  logic [DATAWIDTH-1:0] wdata_a [NPORTS];
  logic [ADDRWIDTH-1:0] sel_addr;
  mem_op_t              sel_op;
  logic                 commit;
  logic [DATAWIDTH-1:0] rd_data;

  logic [DATAWIDTH-1:0] mem     [MEMDEPTH];
  logic                 written [MEMDEPTH];
  mem_rsp_t             pipe    [RD_LAT];

  // Masking requests during reset keeps gnt low and blocks any commit in that cycle.
  assign req_eff = resetH ? '0 : bus.req;

  mem_mp_arb_rr_arbiter #(.N(NPORTS)) u_arb (
    .clk     (clk),
    .resetH  (resetH),
    .req     (req_eff),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
    assign addr_a[i]  = bus.addr[i*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_a[i] = bus.wdata[i*DATAWIDTH +: DATAWIDTH];
  end

  assign bus.gnt  = gnt;
  assign commit   = |gnt;
  assign sel_addr = addr_a[gnt_idx];
  assign sel_op   = mem_op_t'(bus.we[gnt_idx]);
  assign rd_data  = written[sel_addr] ? mem[sel_addr] : UNINIT_VAL;

  // NOTE: the array and its written flags are deliberately not reset; contents survive resetH.
  always_ff @(posedge clk) begin
    if (commit && sel_op == MEM_WR) begin
      mem[sel_addr]     <= wdata_a[gnt_idx];
      written[sel_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: commit && sel_op == MEM_RD,
                   port:  MP_PORT_W'(gnt_idx),
                   data:  rd_data};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.rvalid = pipe[RD_LAT-1].valid ? (NPORTS'(1) << pipe[RD_LAT-1].port) : '0;
  assign bus.rdata  = pipe[RD_LAT-1].data;

`ifdef MEM_MP_PERF_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (resetH) begin
        perf_grants[i*32 +: 32] <= '0;
        perf_stalls[i*32 +: 32] <= '0;
      end else begin
        if (gnt[i] && perf_grants[i*32 +: 32] != 32'hFFFF_FFFF)
          perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
        if (req_eff[i] == 1'b1 && !gnt[i] && perf_stalls[i*32 +: 32] != 32'hFFFF_FFFF)
          perf_stalls[i*32 +: 32] <= perf_stalls[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_mp_arb.sv
// Self-checking bench for mem_mp_arb: directed scenarios plus randomized traffic
// compared against a queue/associative-array reference model.
module tb_mem_mp_arb;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 2**16;
  localparam int AW    = 16;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic resetH;
  always #5 clk = ~clk;

  mem_mp_arb_if #(.NPORTS(NP), .DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

`ifdef MEM_MP_PERF_EN
  logic [NP*32-1:0] perf_grants;
  logic [NP*32-1:0] perf_stalls;
`endif

  mem_mp_arb #(
    .NPORTS(NP), .DATAWIDTH(DW), .MEMDEPTH(DEPTH), .RD_LAT(LAT), .UNINIT_VAL('0)
  ) dut (
    .clk    (clk),
    .resetH (resetH),
    .bus    (bus)
`ifdef MEM_MP_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  int            n_tests = 0;
  int            n_fails = 0;
  int            cyc     = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] m_mem [int];
  rsp_t          m_q [$];
  int            m_grants [NP];
  int            m_stalls [NP];

  logic [NP-1:0] t_req;
  logic [NP-1:0] t_we;
  logic [AW-1:0] t_addr  [NP];
  logic [DW-1:0] t_wdata [NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic apply();
    bus.req   = t_req;
    bus.we    = t_we;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < NP; i++) begin
      bus.addr[i*AW +: AW]  = t_addr[i];
      bus.wdata[i*DW +: DW] = t_wdata[i];
    end
  endtask

  // First requester at or after the model pointer, wrapping; -1 for none or in reset.
  function automatic int exp_grant();
    if (resetH) return -1;
    for (int k = 0; k < NP; k++)
      if (t_req[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
    return -1;
  endfunction

  task automatic cycle(output int g);
    logic [NP-1:0] exp_rv;
    rsp_t          r;
    int            a;
    apply();
    #2;
    g = exp_grant();
    check("gnt", 64'(bus.gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk);
    cyc++;
    if (resetH) begin
      m_ptr = 0;
      m_q.delete();
      for (int p = 0; p < NP; p++) begin m_grants[p] = 0; m_stalls[p] = 0; end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (p == g) m_grants[p]++;
        else if (t_req[p]) m_stalls[p]++;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % NP;
        a = int'(t_addr[g]);
        if (t_we[g]) begin
          m_mem[a] = t_wdata[g];
        end else begin
          r.due  = cyc + LAT - 1;
          r.port = g;
          r.data = m_mem.exists(a) ? m_mem[a] : '0;
          m_q.push_back(r);
        end
      end
    end
    #1;
    exp_rv = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      exp_rv[m_q[0].port] = 1'b1;
      check("rdata", 64'(bus.rdata), 64'(m_q[0].data));
      void'(m_q.pop_front());
    end
    check("rvalid", 64'(bus.rvalid), 64'(exp_rv));
  endtask

  task automatic idle(input int n);
    int g;
    t_req = '0;
    repeat (n) cycle(g);
  endtask

  task automatic single(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    t_req      = '0;
    t_req[p]   = 1'b1;
    t_we[p]    = w;
    t_addr[p]  = a;
    t_wdata[p] = d;
    cycle(g);
    t_req = '0;
  endtask

  initial begin
    int g;
    int wait_c [NP];
    resetH = 1'b1;
    t_req  = '0;
    t_we   = '0;
    for (int p = 0; p < NP; p++) begin
      t_addr[p] = '0; t_wdata[p] = '0; wait_c[p] = 0; m_grants[p] = 0; m_stalls[p] = 0;
    end

    idle(2);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    resetH = 1'b0;

    // Write then read back, then an unwritten location.
    single(0, 1'b1, 16'h0010, 16'hBEEF);
    single(0, 1'b0, 16'h0010, 16'h0000);
    idle(LAT);
    single(1, 1'b0, 16'h1234, 16'h0000);
    idle(LAT);

    // All ports held for 8 cycles from a fresh pointer: grants 0,1,2,3,0,1,2,3.
    resetH = 1'b1;
    idle(1);
    resetH = 1'b0;
    t_req = '1;
    t_we  = '0;
    for (int p = 0; p < NP; p++) t_addr[p] = 16'h0010;
    repeat (8) cycle(g);
    idle(LAT);
`ifdef MEM_MP_PERF_EN
    for (int p = 0; p < NP; p++) check("perf_rr8", 64'(perf_grants[p*32 +: 32]), 64'd2);
`endif

    // Read-after-write across different ports.
    single(1, 1'b1, 16'h0020, 16'h0001);
    single(0, 1'b0, 16'h0020, 16'h0000);
    idle(LAT);

    // Back-to-back reads from ports 2,0,1.
    single(2, 1'b0, 16'h0010, 16'h0000);
    single(0, 1'b0, 16'h0020, 16'h0000);
    single(1, 1'b0, 16'h1234, 16'h0000);
    idle(LAT);

    // Read in flight dropped by reset; write requested during reset never commits.
    single(3, 1'b0, 16'h0010, 16'h0000);
    resetH     = 1'b1;
    t_req      = 4'b0100;
    t_we[2]    = 1'b1;
    t_addr[2]  = 16'h0030;
    t_wdata[2] = 16'hDEAD;
    cycle(g);
    resetH = 1'b0;
    idle(LAT + 1);
    single(0, 1'b0, 16'h0010, 16'h0000);
    single(2, 1'b0, 16'h0030, 16'h0000);
    single(1, 1'b0, 16'h0020, 16'h0000);
    idle(LAT);

    // Random traffic: requests held until granted, occasional reset.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!t_req[p] && $urandom_range(0, 2) == 0) begin
          t_req[p]   = 1'b1;
          t_we[p]    = 1'($urandom_range(0, 1));
          t_addr[p]  = 16'h0100 + 16'($urandom_range(0, 15));
          t_wdata[p] = 16'($urandom);
        end
      end
      resetH = ($urandom_range(0, 59) == 0);
      cycle(g);
      for (int p = 0; p < NP; p++) begin
        if (resetH) begin
          wait_c[p] = 0;
        end else if (t_req[p]) begin
          if (p == g) begin
            check("starve", 64'(wait_c[p] + 1 <= NP), 64'd1);
            wait_c[p] = 0;
            t_req[p]  = 1'b0;
          end else begin
            wait_c[p]++;
          end
        end
      end
    end
    resetH = 1'b0;
    idle(LAT + 1);

`ifdef MEM_MP_PERF_EN
    for (int p = 0; p < NP; p++) begin
      check("perf_grants", 64'(perf_grants[p*32 +: 32]), 64'(m_grants[p]));
      check("perf_stalls", 64'(perf_stalls[p*32 +: 32]), 64'(m_stalls[p]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
